// File: rtl/lmg_move_unpacker_if.sv
// Stream/FIFO bundle between the move-list unpacker and its neighbours.
// master: the unpacker itself; slave: the generator FIFO and downstream consumer side.
interface lmg_move_unpacker_if #(
  parameter int unsigned WORD_W = 160,
  parameter int unsigned CNT_W  = 8
);
  logic              start;
  logic [WORD_W-1:0] fifoOut;
  logic              fifoEmpty;
  logic              rden;
  logic              mv_valid;
  logic              mv_ready;
  logic [5:0]        mv_flags;
  logic [5:0]        mv_from;
  logic [5:0]        mv_to;
  logic [CNT_W-1:0]  mv_count;
  logic              busy;
  logic              list_done;

  modport master (
    input  start, fifoOut, fifoEmpty, mv_ready,
    output rden, mv_valid, mv_flags, mv_from, mv_to, mv_count, busy, list_done
  );

  modport slave (
    output start, fifoOut, fifoEmpty, mv_ready,
    input  rden, mv_valid, mv_flags, mv_from, mv_to, mv_count, busy, list_done
  );
endinterface

// File: rtl/lmg_move_unpacker.sv
// Reader end of the legal-move-generator FIFO: pops packed words, skips invalid slots and
// streams valid moves one per valid/ready handshake, counting accepted moves.
module lmg_move_unpacker #(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned MV_W   = 19,
  parameter int unsigned WORD_W = 160,
  parameter int unsigned CNT_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  lmg_move_unpacker_if.master bus
);

  localparam int unsigned IdxW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned BufW  = SLOTS * MV_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SLOTS - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StRead, StLoad, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   word_q, word_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [MV_W-1:0]   slots [SLOTS];
  logic [MV_W-1:0]   cur_slot;
  logic              cur_valid;
  logic              unused_hi_bits;

  // Bits of the FIFO word above the packed slots carry nothing.
  assign unused_hi_bits = ^bus.fifoOut[WORD_W-1:BufW];

  // Slot 0 sits in the most significant packed position.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign slots[k] = word_q[BufW-1-k*MV_W -: MV_W];
  end

  assign cur_slot  = slots[idx_q];
  assign cur_valid = (state_q == StEmit) && !cur_slot[MV_W-1];

  // Next-state logic: list sequencing, word capture, slot walk and saturating count.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StCheck;
          count_d = '0;
        end
      end
      StCheck: state_d = bus.fifoEmpty ? StDone : StRead;
      StRead:  state_d = StLoad;
      StLoad: begin
        word_d  = bus.fifoOut[BufW-1:0];
        idx_d   = '0;
        state_d = StEmit;
      end
      StEmit: begin
        // Invalid slots cost one cycle; valid ones wait for the consumer.
        if (!cur_valid || bus.mv_ready) begin
          if (cur_valid && (count_q != '1)) count_d = count_q + CNT_W'(1);
          if (idx_q == LastIdx) state_d = StCheck;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  // State and registered status flags; reset discards any buffered word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output decode; move fields read as zero whenever no move is offered.
  always_comb begin
    bus.rden      = (state_q == StCheck) && !bus.fifoEmpty;
    bus.mv_valid  = cur_valid;
    bus.mv_flags  = cur_valid ? cur_slot[17:12] : 6'd0;
    bus.mv_from   = cur_valid ? cur_slot[11:6]  : 6'd0;
    bus.mv_to     = cur_valid ? cur_slot[5:0]   : 6'd0;
    bus.mv_count  = count_q;
    bus.busy      = busy_q;
    bus.list_done = done_q;
  end

endmodule

// File: tb/tb_lmg_move_unpacker.sv
// Bench for lmg_move_unpacker: FIFO model that queues the expected valid moves as words
// are popped, plus one per-cycle compare process and directed literal checks.
module tb_lmg_move_unpacker;
  localparam int unsigned SLOTS  = 8;
  localparam int unsigned MV_W   = 19;
  localparam int unsigned WORD_W = 160;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lmg_move_unpacker_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  lmg_move_unpacker #(
    .SLOTS(SLOTS), .MV_W(MV_W), .WORD_W(WORD_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [MV_W-1:0] mvv(input int f, input int fr, input int t);
    return {1'b0, 6'(f), 6'(fr), 6'(t)};
  endfunction

  function automatic logic [WORD_W-1:0] mk8(
      input logic [MV_W-1:0] s0, input logic [MV_W-1:0] s1, input logic [MV_W-1:0] s2,
      input logic [MV_W-1:0] s3, input logic [MV_W-1:0] s4, input logic [MV_W-1:0] s5,
      input logic [MV_W-1:0] s6, input logic [MV_W-1:0] s7);
    return {8'hA5, s0, s1, s2, s3, s4, s5, s6, s7};
  endfunction

  localparam logic [MV_W-1:0] INV_A = 19'h7FFFF;
  localparam logic [MV_W-1:0] INV_B = 19'h42AB5;

  // FIFO model: registered read data, moves of each popped word queued in slot order.
  logic [WORD_W-1:0] fq [$];
  logic [MV_W-1:0]   exp_q [$];
  logic [WORD_W-1:0] pop_w;
  logic [MV_W-1:0]   pop_s;
  int                fifo_n = 0;
  int                exp_cnt = 0;
  int                rden_pulses = 0;
  bit                clear_on_start = 0;
  bit                prev_rden = 0;
  int                ready_mode = 0;

  assign bus.fifoEmpty = (fifo_n == 0);

  always @(posedge clk) begin
    if (bus.rden && fq.size() > 0) begin
      pop_w = fq.pop_front();
      bus.fifoOut <= pop_w;
      for (int k = 0; k < SLOTS; k++) begin
        pop_s = MV_W'(pop_w >> ((SLOTS - 1 - k) * MV_W));
        if (!pop_s[MV_W-1]) exp_q.push_back(pop_s);
      end
    end
    fifo_n <= fq.size();
  end

  // Compare process: every cycle out of reset.
  logic [MV_W-1:0] head;
  always @(negedge clk) begin
    if (reset) begin
      chk("mv_count", 32'(bus.mv_count), 32'(exp_cnt));
      if (bus.rden) begin
        rden_pulses++;
        chk("rden_while_empty", 32'(bus.fifoEmpty), 32'd0);
        chk("rden_back_to_back", 32'(prev_rden), 32'd0);
      end
      prev_rden = bus.rden;
      if (bus.mv_valid) begin
        chk("move_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          head = exp_q[0];
          chk("move_fields", 32'({bus.mv_flags, bus.mv_from, bus.mv_to}), 32'(head[17:0]));
          if (bus.mv_ready) begin
            void'(exp_q.pop_front());
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
          end
        end
      end
      if (bus.start && clear_on_start) begin
        exp_cnt = 0;
        clear_on_start = 0;
      end
    end else begin
      prev_rden = 0;
    end
  end

  // Consumer: always ready, or toggling every cycle.
  initial begin
    bus.mv_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) bus.mv_ready = ~bus.mv_ready;
      else bus.mv_ready = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic push(input logic [WORD_W-1:0] w);
    fq.push_back(w);
  endtask

  task automatic do_start(input bit fresh);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    clear_on_start = fresh;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!bus.list_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_within_budget", 32'(bus.list_done), 32'd1);
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!bus.mv_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk("valid_within_budget", 32'(bus.mv_valid), 32'd1);
  endtask

  int cyc;
  int run;
  int b;

  initial begin
    bus.start = 1'b0;
    bus.fifoOut = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mv_valid", 32'(bus.mv_valid), 32'd0);
    chk("rst_rden", 32'(bus.rden), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_list_done", 32'(bus.list_done), 32'd0);
    chk("rst_mv_count", 32'(bus.mv_count), 32'd0);
    chk("rst_fields", 32'({bus.mv_flags, bus.mv_from, bus.mv_to}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: empty FIFO -> one CHECK cycle then DONE, no read.
    rden_pulses = 0;
    do_start(1);
    @(negedge clk);
    chk("t1_busy_in_check", 32'(bus.busy), 32'd1);
    chk("t1_not_done_yet", 32'(bus.list_done), 32'd0);
    wait_done(20, cyc);
    chk("t1_done_latency", 32'(cyc), 32'd1);
    chk("t1_count", 32'(bus.mv_count), 32'd0);
    chk("t1_rden_pulses", 32'(rden_pulses), 32'd0);

    // 2: one full word, always ready -> 8 back-to-back moves.
    rden_pulses = 0;
    push(mk8(mvv(1, 12, 28), mvv(2, 13, 29), mvv(3, 14, 30), mvv(4, 15, 31),
             mvv(5, 16, 32), mvv(6, 17, 33), mvv(7, 18, 34), mvv(8, 19, 35)));
    do_start(1);
    wait_valid(20, cyc);
    chk("t2_first_valid_latency", 32'(cyc), 32'd4);
    chk("t2_first_from", 32'(bus.mv_from), 32'd12);
    run = 1;
    b = 0;
    while (b < 20) begin
      @(negedge clk);
      b++;
      if (!bus.mv_valid) break;
      run++;
    end
    chk("t2_consecutive_moves", 32'(run), 32'd8);
    wait_done(20, cyc);
    chk("t2_count", 32'(bus.mv_count), 32'd8);
    chk("t2_rden_pulses", 32'(rden_pulses), 32'd1);
    chk("t2_all_moves_seen", 32'(exp_q.size()), 32'd0);

    // 3: only slot 0 valid.
    rden_pulses = 0;
    push(mk8(19'h20C1C, INV_A, INV_B, INV_A, INV_B, INV_A, INV_B, INV_A));
    do_start(1);
    wait_valid(20, cyc);
    chk("t3_first_valid_latency", 32'(cyc), 32'd4);
    chk("t3_flags", 32'(bus.mv_flags), 32'h20);
    chk("t3_from", 32'(bus.mv_from), 32'h30);
    chk("t3_to", 32'(bus.mv_to), 32'h1C);
    wait_done(40, cyc);
    chk("t3_tail_cycles", 32'(cyc), 32'd9);
    chk("t3_count", 32'(bus.mv_count), 32'd1);

    // 4: backpressure over three words, 8+7+5 valid moves.
    rden_pulses = 0;
    ready_mode = 1;
    push(mk8(mvv(9, 0, 1), mvv(9, 1, 2), mvv(9, 2, 3), mvv(9, 3, 4),
             mvv(9, 4, 5), mvv(9, 5, 6), mvv(9, 6, 7), mvv(9, 7, 8)));
    push(mk8(mvv(10, 8, 9), mvv(10, 9, 10), mvv(10, 10, 11), INV_A,
             mvv(10, 12, 13), mvv(10, 13, 14), mvv(10, 14, 15), mvv(10, 15, 16)));
    push(mk8(mvv(11, 16, 17), INV_B, mvv(11, 18, 19), mvv(11, 19, 20),
             INV_A, mvv(11, 21, 22), INV_B, mvv(11, 23, 24)));
    do_start(1);
    wait_done(300, cyc);
    chk("t4_count", 32'(bus.mv_count), 32'd20);
    chk("t4_rden_pulses", 32'(rden_pulses), 32'd3);
    chk("t4_all_moves_seen", 32'(exp_q.size()), 32'd0);
    chk("t4_not_busy", 32'(bus.busy), 32'd0);
    ready_mode = 0;

    // 5: reset in the middle of word 2, then resume with word 3.
    rden_pulses = 0;
    push(mk8(mvv(20, 1, 1), mvv(20, 2, 2), mvv(20, 3, 3), mvv(20, 4, 4),
             mvv(20, 5, 5), mvv(20, 6, 6), mvv(20, 7, 7), mvv(20, 8, 8)));
    push(mk8(mvv(21, 1, 1), mvv(21, 2, 2), mvv(21, 3, 3), mvv(21, 4, 4),
             mvv(21, 5, 5), mvv(21, 6, 6), mvv(21, 7, 7), mvv(21, 8, 8)));
    push(mk8(mvv(22, 1, 1), INV_A, mvv(22, 3, 3), mvv(22, 4, 4),
             INV_B, mvv(22, 6, 6), mvv(22, 7, 7), mvv(22, 8, 8)));
    do_start(1);
    b = 0;
    while (rden_pulses < 2 && b < 100) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    chk("t5_in_emit_word2", 32'(bus.mv_valid), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    chk("t5_rst_mv_valid", 32'(bus.mv_valid), 32'd0);
    chk("t5_rst_count", 32'(bus.mv_count), 32'd0);
    chk("t5_rst_rden", 32'(bus.rden), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    rden_pulses = 0;
    do_start(1);
    wait_done(100, cyc);
    chk("t5_resume_count", 32'(bus.mv_count), 32'd6);
    chk("t5_resume_rden", 32'(rden_pulses), 32'd1);
    chk("t5_all_moves_seen", 32'(exp_q.size()), 32'd0);

    // 6: start while busy is ignored; start from DONE restarts the count.
    ready_mode = 1;
    push(mk8(mvv(30, 1, 2), mvv(30, 2, 3), mvv(30, 3, 4), mvv(30, 4, 5),
             mvv(30, 5, 6), mvv(30, 6, 7), mvv(30, 7, 8), mvv(30, 8, 9)));
    do_start(1);
    repeat (6) @(negedge clk);
    do_start(0);
    wait_done(200, cyc);
    chk("t6_count_ignored_start", 32'(bus.mv_count), 32'd8);
    chk("t6_all_moves_seen", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;
    rden_pulses = 0;
    push(mk8(INV_A, INV_B, INV_A, INV_B, INV_A, INV_B, INV_A, INV_B));
    push(mk8(INV_A, mvv(31, 9, 10), INV_B, INV_A, INV_B, INV_A, mvv(31, 11, 12), INV_A));
    do_start(1);
    wait_done(100, cyc);
    chk("t6_restart_count", 32'(bus.mv_count), 32'd2);
    chk("t6_rden_pulses", 32'(rden_pulses), 32'd2);
    chk("t6_list_done", 32'(bus.list_done), 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
